redma_job_scheduler: RTL and testbench

REDMA_JOB_SCHEDULER -- requirements
Module: redma_job_scheduler

---
 rtl/redma_sched_pkg.sv | 38 +++
 rtl/redma_axil_wr.sv | 64 ++++++
 rtl/redma_job_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_redma_job_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redma_sched_pkg.sv
// redma_sched_pkg
// Shared definitions for the DMA job scheduler: DMA control register map,
// START command bit positions, interrupt masks and the scheduler state enum.
package redma_sched_pkg;

  // DMA control register map (byte addresses on the AXI-Lite control port)
  localparam logic [31:0] ADDR_START        = 32'h0000_0000;
  localparam logic [31:0] ADDR_ENABLE_INTR  = 32'h0000_0004;
  localparam logic [31:0] ADDR_TOGGLE_INTR  = 32'h0000_000C;
  localparam logic [31:0] ADDR_READER_START = 32'h0000_0010;
  localparam logic [31:0] ADDR_WRITER_START = 32'h0000_0020;
  localparam logic [31:0] ADDR_BTT          = 32'h0000_0030;

  // START register bit positions
  localparam int START_READER_BIT     = 0;
  localparam int START_WRITER_BIT     = 1;
  localparam int START_WRITE_ZERO_BIT = 8;

  // Reader + writer kicked together; write_zero stays clear.
  localparam logic [31:0] START_CMD =
    (32'd1 << START_READER_BIT) | (32'd1 << START_WRITER_BIT);

  // Writer-done interrupt bit, used for both enable and toggle-clear.
  localparam logic [31:0] INTR_WRITER_MASK = 32'h0000_0002;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_ARB,
    ST_WR_RD,
    ST_WR_WR,
    ST_WR_BTT,
    ST_WR_GO,
    ST_WAIT_INTR,
    ST_WR_ACK,
    ST_RESP
  } sched_state_t;

endpackage

// File: rtl/redma_axil_wr.sv
// redma_axil_wr
// Issues one AXI-Lite write per start pulse. AW and W are raised together and
// each is dropped on its own ready; the B response is only accepted once both
// have been taken, so a stray bvalid while idle is ignored.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, addr, data     launch a write (ignored while one is in progress)
//   done, err             one-cycle completion pulse, err = bresp != OKAY
//   awaddr/awvalid/awready, wdata/wvalid/wready, bresp/bvalid   AXI-Lite
module redma_axil_wr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        done,
  output logic        err,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid
);

  logic wait_b;
  logic aw_left;
  logic w_left;

  assign aw_left = awvalid && !awready;
  assign w_left  = wvalid && !wready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awaddr  <= '0;
      wdata   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      wait_b  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !awvalid && !wvalid && !wait_b) begin
        awaddr  <= addr;
        wdata   <= data;
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
      end else if (awvalid || wvalid) begin
        awvalid <= aw_left;
        wvalid  <= w_left;
        if (!aw_left && !w_left)
          wait_b <= 1'b1;
      end else if (wait_b && bvalid) begin
        wait_b <= 1'b0;
        done   <= 1'b1;
        err    <= (bresp != 2'b00);
      end
    end
  end

endmodule

// File: rtl/redma_job_scheduler.sv
// redma_job_scheduler
// Round-robin scheduler that accepts DMA jobs from NUM_REQ requesters,
// programs the DMA over AXI-Lite, waits for the writer-done interrupt (with a
// timeout), clears it and returns a completion pulse to the requester.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   req_valid/req_ready                 per-requester job handshake
//   req_rd_addr/req_wr_addr/req_btt     packed job fields, slot i at [32i+:32]
//   rsp_valid, rsp_err                  completion pulse and error flag
//   busy                                job in flight (grant through RESP)
//   intr                                DMA writer-done interrupt (level)
//   io_control_*                        AXI-Lite write master to the DMA
//
// state        | meaning
// -------------+----------------------------------------------------
// ST_INIT      | enable writer interrupt once after reset
// ST_ARB       | round-robin search, grant and capture job
// ST_WR_RD     | write READER_START
// ST_WR_WR     | write WRITER_START (btt==0 jumps to ST_RESP)
// ST_WR_BTT    | write BTT
// ST_WR_GO     | write START (reader + writer)
// ST_WAIT_INTR | wait for intr or timeout
// ST_WR_ACK    | toggle-clear writer interrupt
// ST_RESP      | rsp_valid pulse, back to ST_ARB
module redma_job_scheduler
  import redma_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 2**20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_rd_addr,
  input  logic [NUM_REQ*32-1:0]   req_wr_addr,
  input  logic [NUM_REQ*32-1:0]   req_btt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_err,
  output logic                    busy,
  input  logic                    intr,
  output logic [31:0]             io_control_aw_awaddr,
  output logic [2:0]              io_control_aw_awprot,
  output logic                    io_control_aw_awvalid,
  input  logic                    io_control_aw_awready,
  output logic [31:0]             io_control_w_wdata,
  output logic [3:0]              io_control_w_wstrb,
  output logic                    io_control_w_wvalid,
  input  logic                    io_control_w_wready,
  input  logic [1:0]              io_control_b_bresp,
  input  logic                    io_control_b_bvalid,
  output logic                    io_control_b_bready
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_t   state;
  logic [GW-1:0]  last_grant;
  logic [GW-1:0]  cur_grant;
  logic [GW-1:0]  arb_idx;
  logic           arb_found;
  logic [31:0]    rd_addr_q;
  logic [31:0]    wr_addr_q;
  logic [31:0]    btt_q;
  logic           job_err;
  logic [CW-1:0]  wait_cnt;
  logic           wr_start;
  logic           wr_pend;
  logic           wr_done;
  logic           wr_err;
  logic [31:0]    wr_addr;
  logic [31:0]    wr_data;
  logic           is_wr_state;
  logic           wr_fin;

  assign io_control_aw_awprot = 3'b000;
  assign io_control_w_wstrb   = 4'hF;
  assign io_control_b_bready  = 1'b1;

  // Search starts one past the last grant and wraps.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!arb_found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = GW'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  // Ready is combinational so that valid/ready meet in the grant cycle itself.
  always_comb begin
    req_ready = '0;
    if (state == ST_ARB && arb_found)
      req_ready[arb_idx] = 1'b1;
  end

  assign busy = (state == ST_ARB) ? arb_found : (state != ST_INIT);

  always_comb begin
    wr_addr     = ADDR_START;
    wr_data     = '0;
    is_wr_state = 1'b1;
    case (state)
      ST_INIT:   begin wr_addr = ADDR_ENABLE_INTR;  wr_data = INTR_WRITER_MASK; end
      ST_WR_RD:  begin wr_addr = ADDR_READER_START; wr_data = rd_addr_q;        end
      ST_WR_WR:  begin wr_addr = ADDR_WRITER_START; wr_data = wr_addr_q;        end
      ST_WR_BTT: begin wr_addr = ADDR_BTT;          wr_data = btt_q;            end
      ST_WR_GO:  begin wr_addr = ADDR_START;        wr_data = START_CMD;        end
      ST_WR_ACK: begin wr_addr = ADDR_TOGGLE_INTR;  wr_data = INTR_WRITER_MASK; end
      default:   is_wr_state = 1'b0;
    endcase
  end

  // The write launched on entry to a write state has completed.
  assign wr_fin = wr_pend && wr_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      last_grant <= GW'(NUM_REQ - 1);
      cur_grant  <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      btt_q      <= '0;
      job_err    <= 1'b0;
      wait_cnt   <= '0;
      wr_start   <= 1'b0;
      wr_pend    <= 1'b0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      wr_start <= 1'b0;
      if (is_wr_state && !wr_pend) begin
        wr_start <= 1'b1;
        wr_pend  <= 1'b1;
      end
      if (wr_fin) begin
        wr_pend <= 1'b0;
        job_err <= job_err | wr_err;
      end

      case (state)
        ST_INIT:
          if (wr_fin) state <= ST_ARB;
        ST_ARB:
          if (arb_found) begin
            cur_grant  <= arb_idx;
            last_grant <= arb_idx;
            rd_addr_q  <= req_rd_addr[int'(arb_idx)*32 +: 32];
            wr_addr_q  <= req_wr_addr[int'(arb_idx)*32 +: 32];
            btt_q      <= req_btt[int'(arb_idx)*32 +: 32];
            job_err    <= 1'b0;
            state      <= ST_WR_RD;
          end
        ST_WR_RD:
          if (wr_fin) state <= ST_WR_WR;
        ST_WR_WR:
          if (wr_fin) begin
            if (btt_q == '0) begin
              // Zero-length job: nothing to transfer, no interrupt to wait for.
              rsp_valid[cur_grant] <= 1'b1;
              rsp_err              <= job_err | wr_err;
              state                <= ST_RESP;
            end else begin
              state <= ST_WR_BTT;
            end
          end
        ST_WR_BTT:
          if (wr_fin) state <= ST_WR_GO;
        ST_WR_GO:
          if (wr_fin) begin
            wait_cnt <= '0;
            state    <= ST_WAIT_INTR;
          end
        ST_WAIT_INTR:
          // intr wins over a simultaneous timeout.
          if (intr) begin
            state <= ST_WR_ACK;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            job_err <= 1'b1;
            state   <= ST_WR_ACK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        ST_WR_ACK:
          if (wr_fin) begin
            rsp_valid[cur_grant] <= 1'b1;
            rsp_err              <= job_err | wr_err;
            state                <= ST_RESP;
          end
        ST_RESP: begin
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
          state     <= ST_ARB;
        end
        default:
          state <= ST_INIT;
      endcase
    end
  end

  redma_axil_wr u_axil_wr (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (wr_start),
    .addr    (wr_addr),
    .data    (wr_data),
    .done    (wr_done),
    .err     (wr_err),
    .awaddr  (io_control_aw_awaddr),
    .awvalid (io_control_aw_awvalid),
    .awready (io_control_aw_awready),
    .wdata   (io_control_w_wdata),
    .wvalid  (io_control_w_wvalid),
    .wready  (io_control_w_wready),
    .bresp   (io_control_b_bresp),
    .bvalid  (io_control_b_bvalid)
  );

endmodule

// File: tb/tb_redma_job_scheduler.sv
// tb_redma_job_scheduler
// Directed bench for redma_job_scheduler with an AXI-Lite slave model that
// logs every completed write, plus monitors for grants and responses.
module tb_redma_job_scheduler;

  localparam int NR = 4;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*32-1:0]  req_rd_addr = '0;
  logic [NR*32-1:0]  req_wr_addr = '0;
  logic [NR*32-1:0]  req_btt = '0;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_err;
  logic              busy;
  logic              intr = 1'b0;
  logic [31:0]       awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  always #5 clk = ~clk;

  redma_job_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_rd_addr           (req_rd_addr),
    .req_wr_addr           (req_wr_addr),
    .req_btt               (req_btt),
    .rsp_valid             (rsp_valid),
    .rsp_err               (rsp_err),
    .busy                  (busy),
    .intr                  (intr),
    .io_control_aw_awaddr  (awaddr),
    .io_control_aw_awprot  (awprot),
    .io_control_aw_awvalid (awvalid),
    .io_control_aw_awready (awready),
    .io_control_w_wdata    (wdata),
    .io_control_w_wstrb    (wstrb),
    .io_control_w_wvalid   (wvalid),
    .io_control_w_wready   (wready),
    .io_control_b_bresp    (bresp),
    .io_control_b_bvalid   (bvalid),
    .io_control_b_bready   (bready)
  );

  // ---------------- AXI-Lite slave model + logs ----------------
  int          aw_delay = 0;
  int          w_delay = 0;
  logic        slverr_en = 1'b0;
  logic [31:0] slverr_addr = 32'h0;
  logic        aw_got, w_got;
  int          aw_cnt, w_cnt;
  logic [31:0] got_addr, got_data;

  logic [31:0] log_addr [0:127];
  logic [31:0] log_data [0:127];
  int          log_cyc  [0:127];
  int          log_n = 0;

  int          gr_idx  [0:63];
  int          gr_n = 0;
  int          rsp_idx [0:63];
  logic        rsp_errl[0:63];
  int          rsp_n = 0;
  int          cyc = 0;
  int          aw_hs = 0;
  int          w_hs = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_cnt  <= 0;
      w_cnt   <= 0;
    end else begin
      awready <= 1'b0;
      wready  <= 1'b0;
      if (bvalid) bvalid <= 1'b0;
      if (awvalid && awready) begin
        aw_got   <= 1'b1;
        got_addr <= awaddr;
      end else if (awvalid && !aw_got) begin
        if (aw_cnt >= aw_delay) awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_got    <= 1'b1;
        got_data <= wdata;
      end else if (wvalid && !w_got) begin
        if (w_cnt >= w_delay) wready <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= (slverr_en && got_addr == slverr_addr) ? 2'b10 : 2'b00;
        if (log_n < 128) begin
          log_addr[log_n] <= got_addr;
          log_data[log_n] <= got_data;
          log_cyc[log_n]  <= cyc;
        end
        log_n  <= log_n + 1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        aw_cnt <= 0;
        w_cnt  <= 0;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (awvalid && awready) aw_hs <= cyc;
    if (wvalid && wready)   w_hs  <= cyc;
    if (|(req_valid & req_ready)) begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i] && gr_n < 64) gr_idx[gr_n] <= i;
      gr_n <= gr_n + 1;
    end
    if (|rsp_valid) begin
      for (int i = 0; i < NR; i++)
        if (rsp_valid[i] && rsp_n < 64) rsp_idx[rsp_n] <= i;
      if (rsp_n < 64) rsp_errl[rsp_n] <= rsp_err;
      rsp_n <= rsp_n + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (log_n < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, (log_n >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (rsp_n < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, (rsp_n >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_grant(input int n, input string tag);
    int k = 0;
    while (gr_n < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, (gr_n >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic set_job(input int r, input logic [31:0] rd, input logic [31:0] wr,
                         input logic [31:0] btt);
    req_rd_addr[32*r +: 32] = rd;
    req_wr_addr[32*r +: 32] = wr;
    req_btt[32*r +: 32]     = btt;
  endtask

  task automatic do_job(input int r, input logic [31:0] rd, input logic [31:0] wr,
                        input logic [31:0] btt);
    int g0;
    @(negedge clk);
    set_job(r, rd, wr, btt);
    g0 = gr_n;
    req_valid[r] = 1'b1;
    wait_grant(g0 + 1, "grant_wait");
    req_valid[r] = 1'b0;
    chk("grant_idx", gr_idx[g0], r);
  endtask

  task automatic chk_log(input int i, input logic [31:0] a, input logic [31:0] d,
                         input string tag);
    chk({tag, "_addr"}, log_addr[i], a);
    chk({tag, "_data"}, log_data[i], d);
  endtask

  task automatic pulse_intr();
    @(negedge clk);
    intr = 1'b1;
    @(negedge clk);
    intr = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b, r0, g;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_awvalid",   32'(awvalid),   32'd0);
    chk("rst_wvalid",    32'(wvalid),    32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Single ENABLE_INTR write after reset, then idle
    wait_log(1, "init_wait");
    chk_log(0, 32'h4, 32'h2, "init");
    repeat (15) @(negedge clk);
    chk("init_once",  log_n,          32'd1);
    chk("idle_busy",  32'(busy),      32'd0);
    chk("awprot",     32'(awprot),    32'd0);
    chk("wstrb",      32'(wstrb),     32'hF);
    chk("bready",     32'(bready),    32'd1);

    // Basic job on requester 1 with interrupt
    b = log_n; r0 = rsp_n;
    do_job(1, 32'h1000, 32'h2000, 32'h40);
    wait_log(b + 4, "job1_start_wait");
    chk_log(b,     32'h10, 32'h1000, "job1_rd");
    chk_log(b + 1, 32'h20, 32'h2000, "job1_wr");
    chk_log(b + 2, 32'h30, 32'h40,   "job1_btt");
    chk_log(b + 3, 32'h0,  32'h3,    "job1_go");
    chk("job1_busy", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    pulse_intr();
    wait_rsp(r0 + 1, "job1_rsp_wait");
    wait_log(b + 5, "job1_ack_wait");
    chk_log(b + 4, 32'hC, 32'h2, "job1_ack");
    chk("job1_rsp_idx", rsp_idx[r0], 32'd1);
    chk("job1_rsp_err", 32'(rsp_errl[r0]), 32'd0);
    @(negedge clk);
    chk("job1_idle_busy", 32'(busy), 32'd0);

    // Round-robin: fresh reset, all requesters valid with zero-length jobs
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b = log_n;
    wait_log(b + 1, "rr_init_wait");
    chk_log(b, 32'h4, 32'h2, "rr_init");
    for (int i = 0; i < NR; i++)
      set_job(i, 32'h100 * i, 32'h200 * i, 32'h0);
    r0 = rsp_n; g = gr_n;
    req_valid = '1;
    wait_grant(g + 5, "rr_grant_wait");
    req_valid = '0;
    wait_rsp(r0 + 5, "rr_rsp_wait");
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", gr_idx[g + i], i % NR);
      chk("rr_rsp_idx", rsp_idx[r0 + i], i % NR);
      chk("rr_rsp_err", 32'(rsp_errl[r0 + i]), 32'd0);
    end

    // Delayed awready: W handshake lands 3 cycles before AW
    aw_delay = 3;
    b = log_n; r0 = rsp_n;
    do_job(2, 32'hA0, 32'hB0, 32'h0);
    wait_rsp(r0 + 1, "dly_rsp_wait");
    chk("dly_nwrites", log_n - b, 32'd2);
    chk_log(b,     32'h10, 32'hA0, "dly_rd");
    chk_log(b + 1, 32'h20, 32'hB0, "dly_wr");
    chk("dly_aw_after_w", aw_hs - w_hs, 32'd3);
    chk("dly_rsp_err", 32'(rsp_errl[r0]), 32'd0);
    aw_delay = 0;

    // Timeout: no interrupt, TOGGLE write after TIMEOUT cycles, error reported
    b = log_n; r0 = rsp_n;
    do_job(3, 32'h3000, 32'h4000, 32'h80);
    wait_rsp(r0 + 1, "to_rsp_wait");
    chk("to_nwrites", log_n - b, 32'd5);
    chk_log(b + 3, 32'h0, 32'h3, "to_go");
    chk_log(b + 4, 32'hC, 32'h2, "to_ack");
    chk("to_latency", log_cyc[b + 4] - log_cyc[b + 3], 32'd71);
    chk("to_rsp_idx", rsp_idx[r0], 32'd3);
    chk("to_rsp_err", 32'(rsp_errl[r0]), 32'd1);

    // SLVERR on the BTT write: sequence continues, error reported
    slverr_en = 1'b1;
    slverr_addr = 32'h30;
    b = log_n; r0 = rsp_n;
    do_job(0, 32'h5000, 32'h6000, 32'h10);
    wait_log(b + 4, "se_go_wait");
    chk_log(b + 3, 32'h0, 32'h3, "se_go");
    repeat (3) @(negedge clk);
    pulse_intr();
    wait_rsp(r0 + 1, "se_rsp_wait");
    chk("se_rsp_idx", rsp_idx[r0], 32'd0);
    chk("se_rsp_err", 32'(rsp_errl[r0]), 32'd1);
    slverr_en = 1'b0;

    // Error is cleared on the next grant
    r0 = rsp_n;
    do_job(1, 32'h7000, 32'h8000, 32'h0);
    wait_rsp(r0 + 1, "clr_rsp_wait");
    chk("clr_rsp_err", 32'(rsp_errl[r0]), 32'd0);

    // Reset during WAIT_INTR
    b = log_n; r0 = rsp_n;
    do_job(2, 32'h9000, 32'hA000, 32'h20);
    wait_log(b + 4, "mr_go_wait");
    repeat (5) @(negedge clk);
    chk("mr_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_busy",      32'(busy),      32'd0);
    chk("mr_awvalid",   32'(awvalid),   32'd0);
    chk("mr_wvalid",    32'(wvalid),    32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rsp_err",   32'(rsp_err),   32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    b = log_n;
    wait_log(b + 1, "mr_init_wait");
    chk_log(b, 32'h4, 32'h2, "mr_init");
    repeat (20) @(negedge clk);
    chk("mr_no_rsp", rsp_n - r0, 32'd0);
    chk("mr_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
